// File: rtl/lc4_ss_issue_ctl.sv
// Dual-issue scheduler for the two-pipe LC4 core: decides how many of the decode
// pair enter X, tracks what went to X for load-use detection, and counts stalls/dual issues.
module lc4_ss_issue_ctl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gwe,
    input  logic             i_flush,
    input  logic             i_vld_A,
    input  logic             i_vld_B,
    input  logic [2:0]       i_rs_A,
    input  logic [2:0]       i_rt_A,
    input  logic [2:0]       i_rd_A,
    input  logic             i_rs_re_A,
    input  logic             i_rt_re_A,
    input  logic             i_rd_we_A,
    input  logic             i_is_load_A,
    input  logic             i_is_mem_A,
    input  logic             i_is_ctl_A,
    input  logic [2:0]       i_rs_B,
    input  logic [2:0]       i_rt_B,
    input  logic [2:0]       i_rd_B,
    input  logic             i_rs_re_B,
    input  logic             i_rt_re_B,
    input  logic             i_rd_we_B,
    input  logic             i_is_load_B,
    input  logic             i_is_mem_B,
    output logic             o_issue_A,
    output logic             o_issue_B,
    output logic             o_switch,
    output logic [1:0]       o_fetch_adv,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_dual_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       xa_vld, xa_rd_we, xa_is_load;
    logic [2:0] xa_rd;
    logic       xb_vld, xb_rd_we, xb_is_load;
    logic [2:0] xb_rd;

    logic lu_a, lu_b, raw_ab, issue_a, issue_b;

    // A consumer stalls on any valid X-stage load that writes one of its enabled sources
    function automatic logic load_hit(
        input logic       vld,
        input logic       is_load,
        input logic       rd_we,
        input logic [2:0] rd,
        input logic [2:0] rs,
        input logic       rs_re,
        input logic [2:0] rt,
        input logic       rt_re
    );
        return vld & is_load & rd_we & ((rs_re & (rs == rd)) | (rt_re & (rt == rd)));
    endfunction

    always_comb begin
        lu_a = load_hit(xa_vld, xa_is_load, xa_rd_we, xa_rd, i_rs_A, i_rs_re_A, i_rt_A, i_rt_re_A)
             | load_hit(xb_vld, xb_is_load, xb_rd_we, xb_rd, i_rs_A, i_rs_re_A, i_rt_A, i_rt_re_A);
        lu_b = load_hit(xa_vld, xa_is_load, xa_rd_we, xa_rd, i_rs_B, i_rs_re_B, i_rt_B, i_rt_re_B)
             | load_hit(xb_vld, xb_is_load, xb_rd_we, xb_rd, i_rs_B, i_rs_re_B, i_rt_B, i_rt_re_B);
        raw_ab = i_rd_we_A & ((i_rs_re_B & (i_rs_B == i_rd_A)) | (i_rt_re_B & (i_rt_B == i_rd_A)));
        issue_a = i_vld_A & ~lu_a & ~i_flush;
        // WAW inside the pair is deliberately allowed: the register file lets B win
        issue_b = issue_a & i_vld_B & ~lu_b & ~raw_ab
                & ~(i_is_mem_A & i_is_mem_B) & ~i_is_ctl_A;
    end

    assign o_issue_A   = issue_a;
    assign o_issue_B   = issue_b;
    assign o_switch    = issue_a & i_vld_B & ~issue_b;
    assign o_fetch_adv = issue_b ? 2'd2 : (issue_a ? 2'd1 : 2'd0);

    // A stall or flush leaves a bubble in X because the valid bits follow the issue decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa_vld     <= 1'b0;
            xa_rd      <= 3'd0;
            xa_rd_we   <= 1'b0;
            xa_is_load <= 1'b0;
            xb_vld     <= 1'b0;
            xb_rd      <= 3'd0;
            xb_rd_we   <= 1'b0;
            xb_is_load <= 1'b0;
        end else if (gwe) begin
            xa_vld     <= issue_a;
            xa_rd      <= i_rd_A;
            xa_rd_we   <= i_rd_we_A;
            xa_is_load <= i_is_load_A;
            xb_vld     <= issue_b;
            xb_rd      <= i_rd_B;
            xb_rd_we   <= i_rd_we_B;
            xb_is_load <= i_is_load_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stall_cnt <= '0;
            o_dual_cnt  <= '0;
        end else if (gwe) begin
            if (i_vld_A && !issue_a && !i_flush && o_stall_cnt != CNT_MAX)
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            if (issue_b && o_dual_cnt != CNT_MAX)
                o_dual_cnt <= o_dual_cnt + CNT_W'(1);
        end
    end

endmodule
